// File: rtl/spi_pkg.sv
// Shared definitions for the SPI loopback fabric: word width, mode codes,
// master FSM states and the mode-to-clock-configuration decode.
package spi_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_DONE
  } mstate_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_cfg_t;

  // MODE 0..3 maps to {CPOL,CPHA} = 00, 01, 11, 10.
  function automatic spi_cfg_t mode_decode(input logic [1:0] mode);
    spi_cfg_t cfg;
    case (mode)
      MODE0:   cfg = '{cpol: 1'b0, cpha: 1'b0};
      MODE1:   cfg = '{cpol: 1'b0, cpha: 1'b1};
      MODE2:   cfg = '{cpol: 1'b1, cpha: 1'b1};
      default: cfg = '{cpol: 1'b1, cpha: 1'b0};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/spi_master.sv
// SPI master: transfer FSM, SCLK generation, slave-select drive and the
// master side of the full-duplex shift path.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SCLK_HALF = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic [2:0]       ss_req_i,
  input  logic             start_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             miso_i,
  output logic             sclk_o,
  output logic             mosi_o,
  output logic [2:0]       ss_n_o,
  output logic             busy_o,
  output logic             idle_o,
  output logic             cpol_o,
  output logic             cpha_o,
  output logic [WIDTH-1:0] shift_o,
  output logic [WIDTH-1:0] main_o
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int EW = $clog2(2 * WIDTH + 1);

  mstate_e          state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
  logic             sclk_q, sclk_d;
  logic [2:0]       ss_q, ss_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             start_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             hold_q, hold_d;
  logic             tx_q, tx_d;

  spi_cfg_t mode_cfg;
  logic     start_rise;
  logic     half_done;

  assign mode_cfg   = mode_decode(mode_i);
  assign start_rise = start_i & ~start_q;
  assign half_done  = (cnt_q == CW'(SCLK_HALF - 1));

  // Next-state and datapath update for the transfer FSM.
  // NOTE: every _d gets its hold value first so no path leaves it unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    ss_d       = ss_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    shift_d    = shift_q;
    main_d     = main_q;
    hold_d     = hold_q;
    tx_d       = tx_q;

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = mode_cfg.cpol;
        if (load_i) begin
          shift_d = data_i;
          main_d  = data_i;
        end
        if (start_rise) begin
          state_d    = ST_SETUP;
          cpol_d     = mode_cfg.cpol;
          cpha_d     = mode_cfg.cpha;
          ss_d       = ss_req_i;
          cnt_d      = '0;
          edge_cnt_d = '0;
        end
      end

      ST_SETUP: begin
        if (half_done) begin
          cnt_d   = '0;
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_XFER: begin
        if (!half_done) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          // A trailing half-period follows the last edge so the slaves,
          // which act one CLK late, still see their select asserted.
          if (edge_cnt_q == EW'(2 * WIDTH)) begin
            state_d = ST_DONE;
            ss_d    = '1;
          end else begin
            sclk_d     = ~sclk_q;
            edge_cnt_d = edge_cnt_q + 1'b1;
            if (sclk_q == cpol_q) begin
              // Leading edge: SCLK leaves its idle level.
              if (cpha_q) begin
                tx_d    = shift_q[WIDTH-1];
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
              end else begin
                hold_d = miso_i;
              end
            end else begin
              // Trailing edge: SCLK returns to its idle level.
              if (cpha_q) begin
                shift_d = {shift_q[WIDTH-1:1], miso_i};
              end else begin
                shift_d = {shift_q[WIDTH-2:0], hold_q};
              end
            end
          end
        end
      end

      ST_DONE: begin
        sclk_d  = cpol_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any transfer and clears all data.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      ss_q       <= '1;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      start_q    <= 1'b0;
      shift_q    <= '0;
      main_q     <= '0;
      hold_q     <= 1'b0;
      tx_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      start_q    <= start_i;
      shift_q    <= shift_d;
      main_q     <= main_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
    end
  end

  // While idle (including during reset) SCLK follows the live MODE's CPOL.
  assign sclk_o  = (state_q == ST_IDLE) ? mode_cfg.cpol : sclk_q;
  assign mosi_o  = cpha_q ? tx_q : shift_q[WIDTH-1];
  assign ss_n_o  = ss_q;
  assign busy_o  = (state_q == ST_SETUP) || (state_q == ST_XFER);
  assign idle_o  = (state_q == ST_IDLE);
  assign cpol_o  = cpol_q;
  assign cpha_o  = cpha_q;
  assign shift_o = shift_q;
  assign main_o  = main_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave in the system clock domain: detects SCLK edges by registering
// SCLK and runs the slave side of the shift path while selected.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sclk_i,
  input  logic             ss_n_i,
  input  logic             mosi_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             miso_o,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] main_o
);

  logic             sclk_prev_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             hold_q, hold_d;
  logic             tx_q, tx_d;

  logic sclk_edge;
  logic lead;
  logic trail;

  assign sclk_edge = sclk_i ^ sclk_prev_q;
  assign lead      = sclk_edge & (sclk_i != cpol_i);
  assign trail     = sclk_edge & (sclk_i == cpol_i);

  // Shift on detected SCLK edges while selected; load only while deselected.
  always_comb begin
    shift_d = shift_q;
    main_d  = main_q;
    hold_d  = hold_q;
    tx_d    = tx_q;
    if (!ss_n_i) begin
      if (lead) begin
        if (cpha_i) begin
          tx_d    = shift_q[WIDTH-1];
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
          hold_d = mosi_i;
        end
      end else if (trail) begin
        if (cpha_i) begin
          shift_d = {shift_q[WIDTH-1:1], mosi_i};
        end else begin
          shift_d = {shift_q[WIDTH-2:0], hold_q};
        end
      end
    end else if (load_i) begin
      shift_d = data_i;
      main_d  = data_i;
    end
  end

  // Slave registers and SCLK history for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_prev_q <= 1'b0;
      shift_q     <= '0;
      main_q      <= '0;
      hold_q      <= 1'b0;
      tx_q        <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_i;
      shift_q     <= shift_d;
      main_q      <= main_d;
      hold_q      <= hold_d;
      tx_q        <= tx_d;
    end
  end

  assign miso_o  = cpha_i ? tx_q : shift_q[WIDTH-1];
  assign state_o = shift_q;
  assign main_o  = main_q;

endmodule

// File: rtl/spi_link.sv
// SPI loopback fabric: one master and three slaves on a shared bus, with
// the MISO priority mux and the selected-slave main-register view.
module spi_link
  import spi_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SCLK_HALF = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       MODE,
  input  logic [2:0]       SS_IN,
  input  logic             START,
  input  logic             LOAD_M,
  input  logic [WIDTH-1:0] DATA_M,
  input  logic             LOAD_S,
  input  logic [WIDTH-1:0] DATA_S,
  output logic             SCLK,
  output logic             BUSY,
  output logic [WIDTH-1:0] OUT_STATE_MASTER,
  output logic [WIDTH-1:0] OUT_MAIN_MASTER,
  output logic [WIDTH-1:0] OUT_STATE_S1,
  output logic [WIDTH-1:0] OUT_STATE_S2,
  output logic [WIDTH-1:0] OUT_STATE_S3,
  output logic [WIDTH-1:0] OUT_MAIN_SLAVE
);

  logic             sclk;
  logic             mosi;
  logic             miso;
  logic [2:0]       ss_n;
  logic             idle;
  logic             cpol;
  logic             cpha;
  logic [2:0]       s_miso;
  logic [WIDTH-1:0] s_state [3];
  logic [WIDTH-1:0] s_main  [3];
  logic [WIDTH-1:0] main_slave_q, main_slave_d;

  spi_master #(
    .WIDTH    (WIDTH),
    .SCLK_HALF(SCLK_HALF)
  ) u_master (
    .clk_i   (CLK),
    .rst_i   (RST),
    .mode_i  (MODE),
    .ss_req_i(SS_IN),
    .start_i (START),
    .load_i  (LOAD_M),
    .data_i  (DATA_M),
    .miso_i  (miso),
    .sclk_o  (sclk),
    .mosi_o  (mosi),
    .ss_n_o  (ss_n),
    .busy_o  (BUSY),
    .idle_o  (idle),
    .cpol_o  (cpol),
    .cpha_o  (cpha),
    .shift_o (OUT_STATE_MASTER),
    .main_o  (OUT_MAIN_MASTER)
  );

  for (genvar i = 0; i < 3; i++) begin : g_slave
    spi_slave #(
      .WIDTH(WIDTH)
    ) u_slave (
      .clk_i  (CLK),
      .rst_i  (RST),
      .sclk_i (sclk),
      .ss_n_i (ss_n[i]),
      .mosi_i (mosi),
      .cpol_i (cpol),
      .cpha_i (cpha),
      .load_i (LOAD_S & idle),
      .data_i (DATA_S),
      .miso_o (s_miso[i]),
      .state_o(s_state[i]),
      .main_o (s_main[i])
    );
  end

  // MISO priority: slave1, then slave2, then slave3, else a quiet bus.
  always_comb begin
    if (!ss_n[0])      miso = s_miso[0];
    else if (!ss_n[1]) miso = s_miso[1];
    else if (!ss_n[2]) miso = s_miso[2];
    else               miso = 1'b0;
  end

  // Selected slave's main byte, same priority; holds when none selected.
  always_comb begin
    main_slave_d = main_slave_q;
    if (!ss_n[0])      main_slave_d = s_main[0];
    else if (!ss_n[1]) main_slave_d = s_main[1];
    else if (!ss_n[2]) main_slave_d = s_main[2];
  end

  // Register for the selected-slave main byte.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) main_slave_q <= '0;
    else     main_slave_q <= main_slave_d;
  end

  assign SCLK           = sclk;
  assign OUT_STATE_S1   = s_state[0];
  assign OUT_STATE_S2   = s_state[1];
  assign OUT_STATE_S3   = s_state[2];
  assign OUT_MAIN_SLAVE = main_slave_q;

endmodule

// File: tb/tb_spi_link.sv
// Directed bench for spi_link: table of single-transfer vectors plus
// hand-written sequences for mid-transfer reset and a no-slave transfer.
module tb_spi_link;
  import spi_pkg::*;

  localparam int W = 8;
  localparam int H = 2;
  localparam int BUSY_CYC = (2 * W + 2) * H;

  logic         CLK = 1'b0;
  logic         RST;
  logic [1:0]   MODE;
  logic [2:0]   SS_IN;
  logic         START;
  logic         LOAD_M;
  logic [W-1:0] DATA_M;
  logic         LOAD_S;
  logic [W-1:0] DATA_S;
  logic         SCLK;
  logic         BUSY;
  logic [W-1:0] OUT_STATE_MASTER;
  logic [W-1:0] OUT_MAIN_MASTER;
  logic [W-1:0] OUT_STATE_S1;
  logic [W-1:0] OUT_STATE_S2;
  logic [W-1:0] OUT_STATE_S3;
  logic [W-1:0] OUT_MAIN_SLAVE;

  int checks = 0;
  int errors = 0;

  spi_link #(
    .WIDTH    (W),
    .SCLK_HALF(H)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .MODE            (MODE),
    .SS_IN           (SS_IN),
    .START           (START),
    .LOAD_M          (LOAD_M),
    .DATA_M          (DATA_M),
    .LOAD_S          (LOAD_S),
    .DATA_S          (DATA_S),
    .SCLK            (SCLK),
    .BUSY            (BUSY),
    .OUT_STATE_MASTER(OUT_STATE_MASTER),
    .OUT_MAIN_MASTER (OUT_MAIN_MASTER),
    .OUT_STATE_S1    (OUT_STATE_S1),
    .OUT_STATE_S2    (OUT_STATE_S2),
    .OUT_STATE_S3    (OUT_STATE_S3),
    .OUT_MAIN_SLAVE  (OUT_MAIN_SLAVE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]   mode;
    logic [2:0]   ss;
    logic [W-1:0] dm;
    logic [W-1:0] ds;
    logic [W-1:0] e_m;
    logic [W-1:0] e_s1;
    logic [W-1:0] e_s2;
    logic [W-1:0] e_s3;
    logic [W-1:0] e_ms;
    logic         e_sclk;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] dm, input logic [W-1:0] ds);
    @(negedge CLK);
    DATA_M = dm;
    DATA_S = ds;
    LOAD_M = 1'b1;
    LOAD_S = 1'b1;
    @(negedge CLK);
    LOAD_M = 1'b0;
    LOAD_S = 1'b0;
  endtask

  // Pulse (or raise and keep) START, then follow BUSY until it falls.
  task automatic run_xfer(input bit keep_start, output int busy_cyc, output int edges);
    logic prev;
    int   t;
    busy_cyc = 0;
    edges    = 0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    if (!keep_start) START = 1'b0;
    prev = SCLK;
    t    = 0;
    while (BUSY && t < 1000) begin
      busy_cyc++;
      @(negedge CLK);
      if (SCLK !== prev) edges++;
      prev = SCLK;
      t++;
    end
    check("xfer_timeout", (t < 1000), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int ec;
    int t;

    vecs[0] = '{2'd0, 3'b110, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{2'd1, 3'b101, 8'h55, 8'hAA, 8'hAA, 8'hAA, 8'h55, 8'hAA, 8'hAA, 1'b0};
    vecs[2] = '{2'd2, 3'b011, 8'h55, 8'hF7, 8'hF7, 8'hF7, 8'hF7, 8'h55, 8'hF7, 1'b1};
    vecs[3] = '{2'd3, 3'b101, 8'h93, 8'h4E, 8'h4E, 8'h4E, 8'h93, 8'h4E, 8'h4E, 1'b1};
    vecs[4] = '{2'd1, 3'b100, 8'h3C, 8'hC3, 8'hC3, 8'h3C, 8'h3C, 8'hC3, 8'hC3, 1'b0};

    RST    = 1'b1;
    MODE   = 2'd2;
    SS_IN  = 3'b111;
    START  = 1'b0;
    LOAD_M = 1'b0;
    LOAD_S = 1'b0;
    DATA_M = '0;
    DATA_S = '0;

    // Reset state; SCLK follows CPOL of the live MODE.
    #1;
    check("rst_sclk_mode2", SCLK, 1);
    check("rst_busy", BUSY, 0);
    check("rst_master", OUT_STATE_MASTER, 0);
    check("rst_s1", OUT_STATE_S1, 0);
    check("rst_main_slave", OUT_MAIN_SLAVE, 0);
    MODE = 2'd0;
    #1;
    check("rst_sclk_mode0", SCLK, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 5; i++) begin
      MODE  = vecs[i].mode;
      SS_IN = vecs[i].ss;
      load(vecs[i].dm, vecs[i].ds);
      run_xfer(1'b0, bc, ec);
      @(negedge CLK);
      check($sformatf("v%0d_master", i), OUT_STATE_MASTER, vecs[i].e_m);
      check($sformatf("v%0d_main_master", i), OUT_MAIN_MASTER, vecs[i].dm);
      check($sformatf("v%0d_s1", i), OUT_STATE_S1, vecs[i].e_s1);
      check($sformatf("v%0d_s2", i), OUT_STATE_S2, vecs[i].e_s2);
      check($sformatf("v%0d_s3", i), OUT_STATE_S3, vecs[i].e_s3);
      check($sformatf("v%0d_main_slave", i), OUT_MAIN_SLAVE, vecs[i].e_ms);
      check($sformatf("v%0d_sclk_idle", i), SCLK, vecs[i].e_sclk);
      check($sformatf("v%0d_busy_cycles", i), bc, BUSY_CYC);
      check($sformatf("v%0d_sclk_edges", i), ec, 2 * W);
    end

    // Reset three bits into a mode 0 transfer.
    MODE  = 2'd0;
    SS_IN = 3'b110;
    load(8'hC3, 8'h3C);
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    t = 0;
    while (!BUSY && t < 100) begin
      @(negedge CLK);
      t++;
    end
    repeat (H + 3 * 2 * H) @(negedge CLK);
    check("mid_busy", BUSY, 1);
    #2;
    RST = 1'b1;
    #1;
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_sclk", SCLK, 0);
    check("mid_rst_master", OUT_STATE_MASTER, 0);
    check("mid_rst_main_master", OUT_MAIN_MASTER, 0);
    check("mid_rst_s1", OUT_STATE_S1, 0);
    check("mid_rst_s2", OUT_STATE_S2, 0);
    check("mid_rst_s3", OUT_STATE_S3, 0);
    check("mid_rst_main_slave", OUT_MAIN_SLAVE, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    load(8'h69, 8'h96);
    run_xfer(1'b0, bc, ec);
    @(negedge CLK);
    check("post_rst_master", OUT_STATE_MASTER, 8'h96);
    check("post_rst_s1", OUT_STATE_S1, 8'h69);
    check("post_rst_s2", OUT_STATE_S2, 8'h96);
    check("post_rst_s3", OUT_STATE_S3, 8'h96);
    check("post_rst_main_master", OUT_MAIN_MASTER, 8'h69);
    check("post_rst_main_slave", OUT_MAIN_SLAVE, 8'h96);

    // No slave selected; START then stays high through DONE and beyond.
    SS_IN = 3'b111;
    load(8'hA5, 8'h5A);
    run_xfer(1'b1, bc, ec);
    @(negedge CLK);
    check("nosel_busy_cycles", bc, BUSY_CYC);
    check("nosel_master", OUT_STATE_MASTER, 8'h00);
    check("nosel_s1", OUT_STATE_S1, 8'h5A);
    check("nosel_s2", OUT_STATE_S2, 8'h5A);
    check("nosel_s3", OUT_STATE_S3, 8'h5A);
    check("nosel_main_slave_hold", OUT_MAIN_SLAVE, 8'h96);
    bc = 0;
    repeat (40) begin
      @(negedge CLK);
      if (BUSY) bc++;
    end
    check("start_held_no_retrigger", bc, 0);
    START = 1'b0;
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_link.md
Name: spi_link

Overview:
- Self-contained SPI subsystem: one master (`spi_master`) and three slaves (`spi_slave`) on a shared SCLK/MOSI/MISO bus.
- Master and the slave selected by SS_IN exchange one byte full-duplex, MSB first, in any of four modes.
- Used as a loopback/verification fabric. After a transfer the master shift register holds the slave's byte and the slave register holds the master's byte.

Parameters:
- WIDTH, 8, transfer word length in bits.
- SCLK_HALF, 2, CLK cycles per SCLK half-period (minimum 2).

Ports:
- CLK  in  1  system clock; all logic clocked on its rising edge.
- RST  in  1  asynchronous active-high reset.
- MODE  in  2  SPI mode select, see Behaviour.
- SS_IN  in  3  active-low slave select request; bit0=slave1, bit1=slave2, bit2=slave3.
- START  in  1  a rising edge while idle starts a transfer.
- LOAD_M  in  1  load DATA_M into the master registers (idle only).
- DATA_M  in  WIDTH  master transmit byte.
- LOAD_S  in  1  load DATA_S into all three slaves (idle only).
- DATA_S  in  WIDTH  slave transmit byte.
- SCLK  out  1  bus serial clock.
- BUSY  out  1  high during a transfer.
- OUT_STATE_MASTER  out  WIDTH  master shift register.
- OUT_MAIN_MASTER  out  WIDTH  byte last loaded into master.
- OUT_STATE_S1/S2/S3  out  WIDTH  slave shift registers.
- OUT_MAIN_SLAVE  out  WIDTH  loaded byte of the currently selected slave.

Behaviour:
- Mode decode {CPOL,CPHA}: 0→00, 1→01, 2→11, 3→10. MODE is sampled at transfer start and held until done.
- Reset values: all shift and main registers 0; SS1..3=1; SCLK=CPOL of the current MODE; BUSY=0; master returns to IDLE.
- Reset mid-transfer aborts with no partial result retained.
- Master FSM states: IDLE, SETUP, XFER, DONE.
  - IDLE: LOAD_M=1 sets shift_reg and main_reg to DATA_M. START rising edge (registered edge detect) goes to SETUP. LOAD_M is ignored outside IDLE.
  - SETUP (SCLK_HALF cycles): drive SSn = SS_IN[n]; BUSY=1; SCLK=CPOL.
  - XFER: SCLK toggles every SCLK_HALF CLK cycles for 2*WIDTH edges. Odd edges are leading, even edges trailing.
  - DONE (1 cycle): SCLK=CPOL, all SS deasserted (1), BUSY=0, then IDLE.
- A new transfer requires START to return low and rise again.
- Data movement, identical rule for master and slave:
  - CPHA=0: TX bit = reg[MSB], valid from SETUP. Sample RX into a holding flop on the leading edge. On the trailing edge, reg <= {reg[MSB-1:0], hold}.
  - CPHA=1: on the leading edge, TX flop <= reg[MSB] and reg shifts left. On the trailing edge, the RX bit is written into reg[0].
  - Either way, after WIDTH bits each side's register equals the peer's original byte.
- Slaves run in the CLK domain. Each detects SCLK edges by registering SCLK, acting one CLK after each edge (SCLK_HALF≥2 guarantees setup).
- A slave acts only while its SSn=0. A deselected slave holds its register.
- LOAD_S=1 while its SSn=1 loads DATA_S into that slave's shift and main registers.
- MISO mux: SS1 low→S1, else SS2 low→S2, else SS3 low→S3, else 0.
- Multiple SS_IN bits low: all selected slaves shift; MISO follows the priority above.
- OUT_MAIN_SLAVE follows the same priority; with no slave selected it holds its last value (registered).
- SS_IN=3'b111: the transfer still clocks, master receives all zeros, and no slave changes.
- START held high through DONE does not retrigger.

Decomposition:
- Package spi_pkg: WIDTH default, mode encoding constants, master FSM state enum, mode→{CPOL,CPHA} decode function.
- Sub-modules: spi_master (FSM, SCLK generation, master shift path) and spi_slave (edge detect, shift path), instantiated three times. Top holds the MISO/OUT_MAIN muxes only.

Test Plan:
- Mode 0, SS_IN=011: LOAD_M with DATA_M=FF, LOAD_S with DATA_S=00, then START → OUT_STATE_MASTER=00, OUT_STATE_S1=FF, S2/S3 unchanged, BUSY falls after 8 SCLK periods.
- Mode 1, SS_IN=101: DATA_M=55, DATA_S=AA → master=AA, S2=55, OUT_MAIN_SLAVE=AA, OUT_MAIN_MASTER=55.
- Mode 2, SS_IN=110: DATA_M=55, DATA_S=F7 → master=F7, S3=55; SCLK idles high.
- Mode 3, SS_IN=101: DATA_M=93, DATA_S=4E → master=4E, S2=93.
- RST asserted after 3 bits of a mode 0 transfer → all registers 0, SS all 1, BUSY 0. A following START with reloaded data completes correctly.
- SS_IN=111, DATA_M=A5 → master=00 after transfer; all slave registers unchanged; START held high does not start a second transfer.
